// File: rtl/add4_pg_pkg.sv
// -----------------------------------------------------------------------------
// add4_pg_pkg
//   Shared definitions for the hierarchical carry-lookahead adder datapath.
//   Holds the slice width and the group propagate/generate record that the
//   second-level lookahead unit consumes from each 4-bit slice.
// -----------------------------------------------------------------------------
package add4_pg_pkg;

    localparam int SLICE_W = 4;

    // Group signals of one slice, as seen by the second-level lookahead unit.
    typedef struct packed {
        logic pg;   // group propagate
        logic gg;   // group generate
    } grp_pg_t;

    // Block carry out of a slice given its group signals and its carry in.
    function automatic logic grp_carry(input grp_pg_t grp, input logic c_in);
        return grp.gg | (grp.pg & c_in);
    endfunction

endpackage

// File: rtl/add4_pg_pg_cell.sv
// -----------------------------------------------------------------------------
// pg_cell
//   One-bit carry-lookahead cell: forms the bit propagate and generate and
//   the sum bit from the carry supplied by the lookahead logic.
//   Ports:
//     a, b  in  addend bits
//     c     in  carry into this bit position
//     p     out propagate  (a ^ b)
//     g     out generate   (a & b)
//     s     out sum bit    (p ^ c)
// -----------------------------------------------------------------------------
module pg_cell (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic p,
    output logic g,
    output logic s
);

    assign p = a ^ b;
    assign g = a & b;
    assign s = p ^ c;

endmodule

// File: rtl/add4_pg.sv
// -----------------------------------------------------------------------------
// add4_pg
//   Four-bit carry-lookahead adder slice with group propagate/generate.
//   Sum, group signals and carry out are combinational; a registered copy of
//   each is provided for pipelined consumers.
//   Ports:
//     clk     in   design clock
//     rst     in   synchronous active-high reset (clears *_q only)
//     a, b    in   4-bit addends
//     cin     in   carry into bit 0
//     s       out  (a + b + cin) mod 16, combinational
//     PG, GG  out  group propagate / generate, combinational, cin-independent
//     cout    out  carry out of bit 3, combinational
//     s_q, PG_q, GG_q, cout_q  out  registered copies (one-cycle latency)
// -----------------------------------------------------------------------------
module add4_pg
    import add4_pg_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic [SLICE_W-1:0] a,
    input  logic [SLICE_W-1:0] b,
    input  logic               cin,
    output logic [SLICE_W-1:0] s,
    output logic               PG,
    output logic               GG,
    output logic               cout,
    output logic [SLICE_W-1:0] s_q,
    output logic               PG_q,
    output logic               GG_q,
    output logic               cout_q
);

    logic [SLICE_W-1:0] w_p;
    logic [SLICE_W-1:0] w_g;
    logic [SLICE_W-1:0] w_c;
    logic [SLICE_W-1:0] w_s;
    grp_pg_t            w_grp;

    logic [SLICE_W-1:0] r_s;
    logic               r_pg;
    logic               r_gg;
    logic               r_cout;

    for (genvar i = 0; i < SLICE_W; i++) begin : g_cell
        pg_cell u_cell (
            .a (a[i]),
            .b (b[i]),
            .c (w_c[i]),
            .p (w_p[i]),
            .g (w_g[i]),
            .s (w_s[i])
        );
    end

    // Every carry is a flat sum of products of p/g/cin, so no carry waits on
    // another carry.
    assign w_c[0] = cin;
    assign w_c[1] = w_g[0]
                  | (w_p[0] & cin);
    assign w_c[2] = w_g[1]
                  | (w_p[1] & w_g[0])
                  | (w_p[1] & w_p[0] & cin);
    assign w_c[3] = w_g[2]
                  | (w_p[2] & w_g[1])
                  | (w_p[2] & w_p[1] & w_g[0])
                  | (w_p[2] & w_p[1] & w_p[0] & cin);

    // Group terms exclude cin so the second-level unit can resolve block
    // carries in parallel with the slices.
    assign w_grp.pg = &w_p;
    assign w_grp.gg = w_g[3]
                    | (w_p[3] & w_g[2])
                    | (w_p[3] & w_p[2] & w_g[1])
                    | (w_p[3] & w_p[2] & w_p[1] & w_g[0]);

    assign s    = w_s;
    assign PG   = w_grp.pg;
    assign GG   = w_grp.gg;
    assign cout = grp_carry(w_grp, cin);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s    <= '0;
            r_pg   <= 1'b0;
            r_gg   <= 1'b0;
            r_cout <= 1'b0;
        end else begin
            r_s    <= w_s;
            r_pg   <= w_grp.pg;
            r_gg   <= w_grp.gg;
            r_cout <= cout;
        end
    end

    assign s_q    = r_s;
    assign PG_q   = r_pg;
    assign GG_q   = r_gg;
    assign cout_q = r_cout;

endmodule

// File: tb/tb_add4_pg.sv
module tb_add4_pg;

    logic       clk;
    logic       rst;
    logic [3:0] a;
    logic [3:0] b;
    logic       cin;
    logic [3:0] s;
    logic       PG;
    logic       GG;
    logic       cout;
    logic [3:0] s_q;
    logic       PG_q;
    logic       GG_q;
    logic       cout_q;

    int n_vec;
    int n_err;

    add4_pg dut (
        .clk    (clk),
        .rst    (rst),
        .a      (a),
        .b      (b),
        .cin    (cin),
        .s      (s),
        .PG     (PG),
        .GG     (GG),
        .cout   (cout),
        .s_q    (s_q),
        .PG_q   (PG_q),
        .GG_q   (GG_q),
        .cout_q (cout_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (a=%0h b=%0h cin=%0b rst=%0b)",
                     tag, obs, exp, a, b, cin, rst);
        end
    endtask

    // Reference model from plain arithmetic: the group propagates exactly when
    // a + b == 15 and generates exactly when a + b overflows 4 bits.
    task automatic model(input logic [3:0] ma, input logic [3:0] mb, input logic mc,
                         output logic [3:0] es, output logic ec,
                         output logic epg, output logic egg);
        int sum;
        int ab;
        sum = int'(ma) + int'(mb) + int'(mc);
        ab  = int'(ma) + int'(mb);
        es  = sum[3:0];
        ec  = sum[4];
        epg = (ab == 15);
        egg = (ab >= 16);
    endtask

    // Drive at the falling edge, check combinational outputs, then check the
    // registered copies just after the following rising edge.
    task automatic apply(input logic [3:0] va, input logic [3:0] vb, input logic vc);
        logic [3:0] es;
        logic ec, epg, egg;
        @(negedge clk);
        a = va; b = vb; cin = vc;
        #1;
        model(va, vb, vc, es, ec, epg, egg);
        chk("s",    8'(s),    8'(es));
        chk("cout", 8'(cout), 8'(ec));
        chk("PG",   8'(PG),   8'(epg));
        chk("GG",   8'(GG),   8'(egg));
        @(posedge clk);
        #1;
        chk("s_q",    8'(s_q),    8'(es));
        chk("cout_q", 8'(cout_q), 8'(ec));
        chk("PG_q",   8'(PG_q),   8'(epg));
        chk("GG_q",   8'(GG_q),   8'(egg));
    endtask

    task automatic directed(input logic [3:0] va, input logic [3:0] vb, input logic vc,
                            input logic [3:0] es, input logic ec,
                            input logic epg, input logic egg);
        @(negedge clk);
        a = va; b = vb; cin = vc;
        #1;
        chk("dir_s",    8'(s),    8'(es));
        chk("dir_cout", 8'(cout), 8'(ec));
        chk("dir_PG",   8'(PG),   8'(epg));
        chk("dir_GG",   8'(GG),   8'(egg));
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst = 1'b1;
        a   = 4'h7;
        b   = 4'h9;
        cin = 1'b1;

        // Reset held for two edges: registers cleared, combinational path live.
        repeat (2) begin
            @(posedge clk);
            #1;
            chk("rst_s_q",    8'(s_q),    8'h0);
            chk("rst_cout_q", 8'(cout_q), 8'h0);
            chk("rst_PG_q",   8'(PG_q),   8'h0);
            chk("rst_GG_q",   8'(GG_q),   8'h0);
            chk("rst_s",      8'(s),      8'h1);
            chk("rst_cout",   8'(cout),   8'h1);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("post_s_q",    8'(s_q),    8'h1);
        chk("post_cout_q", 8'(cout_q), 8'h1);
        chk("post_GG_q",   8'(GG_q),   8'h1);
        chk("post_PG_q",   8'(PG_q),   8'h0);

        // Group-signal vectors and cin independence.
        directed(4'hF, 4'h0, 1'b1, 4'h0, 1'b1, 1'b1, 1'b0);
        directed(4'h8, 4'h8, 1'b0, 4'h0, 1'b1, 1'b0, 1'b1);
        directed(4'h5, 4'hA, 1'b0, 4'hF, 1'b0, 1'b1, 1'b0);
        directed(4'h3, 4'h1, 1'b0, 4'h4, 1'b0, 1'b0, 1'b0);
        directed(4'h3, 4'h1, 1'b1, 4'h5, 1'b0, 1'b0, 1'b0);

        // Exhaustive sweep; inputs change every cycle.
        for (int i = 0; i < 512; i++) begin
            logic [8:0] v;
            v = 9'(i);
            apply(v[3:0], v[7:4], v[8]);
        end

        // Randomized vectors.
        for (int i = 0; i < 300; i++) begin
            apply(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                  1'($urandom_range(0, 1)));
        end

        // Reset asserted in the same cycle as an input change: reset wins.
        @(negedge clk);
        rst = 1'b1;
        a = 4'hF; b = 4'hF; cin = 1'b1;
        @(posedge clk);
        #1;
        chk("rw_s_q",    8'(s_q),    8'h0);
        chk("rw_cout_q", 8'(cout_q), 8'h0);
        chk("rw_GG_q",   8'(GG_q),   8'h0);
        chk("rw_s",      8'(s),      8'hF);
        chk("rw_cout",   8'(cout),   8'h1);
        chk("rw_GG",     8'(GG),     8'h1);
        @(negedge clk);
        rst = 1'b0;
        apply(4'hC, 4'h3, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
